message_collection: RTL and testbench
=====================================

Name: message_collection

Overview:
- Receive-side counterpart of message delivery: fetches one message word from a source (sending) process.
- Running source process (currently on core 0 or core 1): flags the owning core to hand the word over directly; no memory traffic.
- Parked source process: pops the top of its in-memory stack, writes back the incremented stack pointer, and optionally rewrites the program counter so the sender resumes at a new address.
- Sits under the channel/scheduler controller, which holds reset low until a collection is required and reasserts it low one cycle after finished.

Parameters:
addrBits, 8, memory address width; also stack-pointer width
dataBits, 16, memory word and message width
emptyStackPointer, 8'd0, SP value meaning "stack empty" (only used with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low; low = idle/restart, high = run
finished  output  1  collection complete
memoryCellReadWriteMode  output  1  RAM_READ / RAM_WRITE
memoryCellAddress  output  addrBits  memory address (x when unused)
memoryCellDataIn  output  dataBits  write data (x when unused)
memoryCellDataOut  input  dataBits  read data
core0Process  input  addrBits  process running on core 0
core1Process  input  addrBits  process running on core 1
sourceProcess  input  addrBits  process to collect from
needsJump  input  1  rewrite source PC after the pop
jumpDestination  input  9  new PC value
message  output  dataBits  collected word, valid while finished && !collectFromCore0 && !collectFromCore1
collectFromCore0  output  1  message must come from core 0
collectFromCore1  output  1  message must come from core 1
underflow  output  1  pop attempted on an empty stack

Behaviour:
- Reset (clk edge, reset==0): state=INIT, ioTicker=0, finished=0, collectFromCore0/1=0, underflow=0, message=0.
- Memory layout:
  - addr 0 = {SP[15:8], CSP[7:0]}.
  - addr 1 = {flags[15:9], PC[8:0]}.
  - Stack grows downward; top of stack is at addr SP.
- State timing:
  - Every state lasts exactly 2 cycles; a 1-bit ioTicker toggles each cycle.
  - Address, mode and data are driven combinationally for both cycles.
  - Read data is registered on each cycle of a read state, so the value sampled on the tick-1 edge is the one kept.
  - State advances and finished updates on the tick-1 edge. Exception: in INIT, finished may also update on the tick-0 edge.
- States:
  - INIT: read addr 0 and capture the SP word.
    - If core0Process==sourceProcess: finished=1 and collectFromCore0=1 on the first edge.
    - Else if core1Process==sourceProcess: finished=1 and collectFromCore1=1 on the first edge.
    - core0 has priority when both match.
    - Otherwise go to READ_TOP.
  - READ_TOP: read addr SP; capture the value into message. Go to WRITE_SP.
  - WRITE_SP: write addr 0 = {SP+1 (mod 2^addrBits), CSP}.
    - needsJump==0: finished=1.
    - needsJump==1: go to READ_PC.
  - READ_PC: read addr 1; capture the word into a scratch register (message is not overwritten). Go to WRITE_PC.
  - WRITE_PC: write addr 1 = {flags[15:9], jumpDestination}; finished=1.
- Latency (cycles from reset going high to finished=1):
  - direct core: 1
  - pop only: 6
  - pop + jump: 10
- After finished: outputs hold their values, no further memory writes, and mode is RAM_READ until reset goes low.
- SP arithmetic is modulo 256: SP=8'hFF pops to 8'h00.
- Reset low mid-operation aborts on that edge. A partially completed sequence is not rolled back (the WRITE_SP/WRITE_PC writes are each atomic).
- needsJump, jumpDestination and sourceProcess must be held stable while reset is high.

Optional Feature:
- MESSAGE_COLLECTION_UNDERFLOW_CHECK_EN defined:
  - In READ_TOP, if captured SP==emptyStackPointer: no read is used and no writes are issued.
  - finished=1 and underflow=1 on the tick-1 edge of READ_TOP (latency 4); message stays 0.
- Undefined:
  - underflow is tied 0.
  - The pop proceeds unconditionally with wrap-around.

Test Plan:
- core0Process=5, core1Process=5, sourceProcess=5, release reset -> finished=1 and collectFromCore0=1 after 1 cycle; collectFromCore1=0; no RAM_WRITE ever.
- Parked process, mem[0]=16'h3A07, mem[8'h3A]=16'hBEEF, needsJump=0 -> finished at cycle 6; message=16'hBEEF; mem[0]=16'h3B07; mem[1] untouched.
- Same setup, needsJump=1, jumpDestination=9'h123, mem[1]=16'hFE00 -> finished at cycle 10; mem[1]=16'hFF23; message=16'hBEEF.
- mem[0]=16'hFF00, mem[8'hFF]=16'h1234 -> message=16'h1234; mem[0]=16'h0000 (wrap).
- With the macro defined, mem[0]=16'h0011 -> finished at cycle 4; underflow=1; mem[0] unchanged; no RAM_WRITE.
- Pull reset low in WRITE_SP tick 0, then release with a new sourceProcess -> state restarts in INIT; all outputs 0 the cycle after the reset edge.

Source files
------------

// File: rtl/message_collection.sv
// Collects one message word from a source process: direct core hand-off, or stack pop (+ optional PC rewrite) in memory; MESSAGE_COLLECTION_UNDERFLOW_CHECK_EN adds an empty-stack check.
// Latency from reset release: 1 cycle (core hand-off), 6 (pop), 10 (pop + jump), 4 (underflow).
// No backpressure: the controller starts the block by releasing reset and ends it by pulling reset low after finished.
module message_collection #(
    parameter int                  addrBits          = 8,
    parameter int                  dataBits          = 16,
    parameter logic [addrBits-1:0] emptyStackPointer = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                finished,
    output logic                memoryCellReadWriteMode,
    output logic [addrBits-1:0] memoryCellAddress,
    output logic [dataBits-1:0] memoryCellDataIn,
    input  logic [dataBits-1:0] memoryCellDataOut,
    input  logic [addrBits-1:0] core0Process,
    input  logic [addrBits-1:0] core1Process,
    input  logic [addrBits-1:0] sourceProcess,
    input  logic                needsJump,
    input  logic [8:0]          jumpDestination,
    output logic [dataBits-1:0] message,
    output logic                collectFromCore0,
    output logic                collectFromCore1,
    output logic                underflow
);

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

`ifdef MESSAGE_COLLECTION_UNDERFLOW_CHECK_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_INIT,
        S_READ_TOP,
        S_WRITE_SP,
        S_READ_PC,
        S_WRITE_PC,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_tick;
    logic                r_finished, w_finished_nxt;
    logic                r_core0, w_core0_nxt;
    logic                r_core1, w_core1_nxt;
    logic                r_underflow, w_underflow_nxt;
    logic [dataBits-1:0] r_message, w_message_nxt;
    logic [dataBits-1:0] r_spWord, w_spWord_nxt;
    logic [dataBits-10:0] r_flags, w_flags_nxt;

    logic                w_mode;
    logic [addrBits-1:0] w_addr;
    logic [dataBits-1:0] w_din;
    logic [addrBits-1:0] w_sp;
    logic [addrBits-1:0] w_sp_inc;
    logic                w_uf_hit;

    assign w_sp     = r_spWord[dataBits-1 -: addrBits];
    assign w_sp_inc = w_sp + 1'b1;
    assign w_uf_hit = UF_EN && (w_sp == emptyStackPointer);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_tick      <= 1'b0;
            r_finished  <= 1'b0;
            r_core0     <= 1'b0;
            r_core1     <= 1'b0;
            r_underflow <= 1'b0;
            r_message   <= '0;
            r_spWord    <= '0;
            r_flags     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick      <= ~r_tick;
            r_finished  <= w_finished_nxt;
            r_core0     <= w_core0_nxt;
            r_core1     <= w_core1_nxt;
            r_underflow <= w_underflow_nxt;
            r_message   <= w_message_nxt;
            r_spWord    <= w_spWord_nxt;
            r_flags     <= w_flags_nxt;
        end
    end

    // Read data is re-captured on both cycles of a read state; the tick-1 sample is the one kept.
    always_comb begin
        w_state_nxt     = r_state;
        w_finished_nxt  = r_finished;
        w_core0_nxt     = r_core0;
        w_core1_nxt     = r_core1;
        w_underflow_nxt = r_underflow;
        w_message_nxt   = r_message;
        w_spWord_nxt    = r_spWord;
        w_flags_nxt     = r_flags;
        w_mode          = RAM_READ;
        w_addr          = 'x;
        w_din           = 'x;
        case (r_state)
            S_INIT: begin
                w_addr       = '0;
                w_spWord_nxt = memoryCellDataOut;
                if (core0Process == sourceProcess) begin
                    w_finished_nxt = 1'b1;
                    w_core0_nxt    = 1'b1;
                    w_state_nxt    = S_DONE;
                end else if (core1Process == sourceProcess) begin
                    w_finished_nxt = 1'b1;
                    w_core1_nxt    = 1'b1;
                    w_state_nxt    = S_DONE;
                end else if (r_tick) begin
                    w_state_nxt = S_READ_TOP;
                end
            end
            S_READ_TOP: begin
                if (w_uf_hit) begin
                    if (r_tick) begin
                        w_finished_nxt  = 1'b1;
                        w_underflow_nxt = 1'b1;
                        w_state_nxt     = S_DONE;
                    end
                end else begin
                    w_addr        = w_sp;
                    w_message_nxt = memoryCellDataOut;
                    if (r_tick) w_state_nxt = S_WRITE_SP;
                end
            end
            S_WRITE_SP: begin
                w_mode = RAM_WRITE;
                w_addr = '0;
                w_din  = {w_sp_inc, r_spWord[dataBits-addrBits-1:0]};
                if (r_tick) begin
                    if (needsJump) begin
                        w_state_nxt = S_READ_PC;
                    end else begin
                        w_finished_nxt = 1'b1;
                        w_state_nxt    = S_DONE;
                    end
                end
            end
            S_READ_PC: begin
                w_addr      = addrBits'(1);
                w_flags_nxt = memoryCellDataOut[dataBits-1:9];
                if (r_tick) w_state_nxt = S_WRITE_PC;
            end
            S_WRITE_PC: begin
                w_mode = RAM_WRITE;
                w_addr = addrBits'(1);
                w_din  = {r_flags, jumpDestination};
                if (r_tick) begin
                    w_finished_nxt = 1'b1;
                    w_state_nxt    = S_DONE;
                end
            end
            S_DONE: begin
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    assign finished                = r_finished;
    assign memoryCellReadWriteMode = w_mode;
    assign memoryCellAddress       = w_addr;
    assign memoryCellDataIn        = w_din;
    assign message                 = r_message;
    assign collectFromCore0        = r_core0;
    assign collectFromCore1        = r_core1;
    assign underflow               = r_underflow;

endmodule

// File: tb/tb_message_collection.sv
// Bench for message_collection: directed cases plus randomized collections against a memory-image reference model.
module tb_message_collection;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;
`ifdef MESSAGE_COLLECTION_UNDERFLOW_CHECK_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        finished;
    logic        memoryCellReadWriteMode;
    logic [7:0]  memoryCellAddress;
    logic [15:0] memoryCellDataIn;
    logic [15:0] memoryCellDataOut;
    logic [7:0]  core0Process = '0;
    logic [7:0]  core1Process = '0;
    logic [7:0]  sourceProcess = '0;
    logic        needsJump = 1'b0;
    logic [8:0]  jumpDestination = '0;
    logic [15:0] message;
    logic        collectFromCore0;
    logic        collectFromCore1;
    logic        underflow;

    logic [15:0] mem     [0:255];
    logic [15:0] img     [0:255];
    logic [15:0] exp_mem [0:255];
    logic        ld = 1'b0;
    int          n_wr;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    message_collection dut (
        .clk                     (clk),
        .reset                   (reset),
        .finished                (finished),
        .memoryCellReadWriteMode (memoryCellReadWriteMode),
        .memoryCellAddress       (memoryCellAddress),
        .memoryCellDataIn        (memoryCellDataIn),
        .memoryCellDataOut       (memoryCellDataOut),
        .core0Process            (core0Process),
        .core1Process            (core1Process),
        .sourceProcess           (sourceProcess),
        .needsJump               (needsJump),
        .jumpDestination         (jumpDestination),
        .message                 (message),
        .collectFromCore0        (collectFromCore0),
        .collectFromCore1        (collectFromCore1),
        .underflow               (underflow)
    );

    // Asynchronous-read RAM with synchronous write, reloadable from img.
    assign memoryCellDataOut = mem[memoryCellAddress];
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            n_wr <= 0;
        end else if (memoryCellReadWriteMode == RAM_WRITE) begin
            mem[memoryCellAddress] <= memoryCellDataIn;
            n_wr <= n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_reset(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] src,
                                  input logic nj, input logic [8:0] jd);
        reset = 1'b0;
        core0Process = c0; core1Process = c1; sourceProcess = src;
        needsJump = nj; jumpDestination = jd;
        ld = 1'b1;
        step();
        ld = 1'b0;
        step();
        check("reset_outputs", {27'd0, finished, collectFromCore0, collectFromCore1, underflow,
                                memoryCellReadWriteMode}, 32'd0);
        check("reset_message", {16'd0, message}, 32'd0);
    endtask

    task automatic run_case(input string name, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] src, input logic nj, input logic [8:0] jd);
        int          e_lat, e_wr, lat, diff;
        logic        e_c0, e_c1, e_uf;
        logic [15:0] e_msg;
        logic [7:0]  sp;
        load_and_reset(c0, c1, src, nj, jd);
        for (int i = 0; i < 256; i++) exp_mem[i] = img[i];
        e_c0 = 1'b0; e_c1 = 1'b0; e_uf = 1'b0; e_msg = 16'h0; e_wr = 0;
        sp = img[0][15:8];
        if (c0 == src) begin
            e_lat = 1; e_c0 = 1'b1;
        end else if (c1 == src) begin
            e_lat = 1; e_c1 = 1'b1;
        end else if (UF_EN && sp == 8'h00) begin
            e_lat = 4; e_uf = 1'b1;
        end else begin
            e_msg = img[sp];
            exp_mem[0] = {sp + 8'd1, img[0][7:0]};
            e_lat = 6; e_wr = 2;
            if (nj) begin
                exp_mem[1] = {exp_mem[1][15:9], jd};
                e_lat = 10; e_wr = 4;
            end
        end
        reset = 1'b1;
        lat = 0;
        for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
            step();
            if (finished) lat = cyc;
        end
        check({name, "_latency"}, lat, e_lat);
        check({name, "_flags"}, {29'd0, collectFromCore0, collectFromCore1, underflow}, {29'd0, e_c0, e_c1, e_uf});
        check({name, "_message"}, {16'd0, message}, {16'd0, e_msg});
        repeat (5) step();
        check({name, "_hold"}, {16'd0, finished, collectFromCore0, collectFromCore1, underflow,
                                memoryCellReadWriteMode, 11'd0}, {16'd0, 1'b1, e_c0, e_c1, e_uf, RAM_READ, 11'd0});
        check({name, "_hold_message"}, {16'd0, message}, {16'd0, e_msg});
        check({name, "_writes"}, n_wr, e_wr);
        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diff++;
        check({name, "_mem_diffs"}, diff, 0);
        reset = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) img[i] = 16'($urandom);

        // Directed: both cores hold the source; core 0 wins
        run_case("direct_c0", 8'd5, 8'd5, 8'd5, 1'b0, 9'h000);
        run_case("direct_c1", 8'd3, 8'd7, 8'd7, 1'b1, 9'h055);

        img[0] = 16'h3A07; img[8'h3A] = 16'hBEEF; img[1] = 16'hFE00;
        run_case("pop", 8'd1, 8'd2, 8'd9, 1'b0, 9'h123);
        run_case("pop_jump", 8'd1, 8'd2, 8'd9, 1'b1, 9'h123);
        check("pop_jump_pc_word", {16'd0, mem[1]}, 32'h0000FF23);

        img[0] = 16'hFF00; img[8'hFF] = 16'h1234;
        run_case("wrap", 8'd1, 8'd2, 8'd9, 1'b0, 9'h000);
        check("wrap_sp_word", {16'd0, mem[0]}, 32'h00000000);

        img[0] = 16'h0011;
        run_case("empty_sp", 8'd1, 8'd2, 8'd9, 1'b1, 9'h1AA);

        // Abort in WRITE_SP tick 0, then restart with a new source
        img[0] = 16'h4002; img[8'h40] = 16'hCAFE;
        load_and_reset(8'd1, 8'd2, 8'd9, 1'b1, 9'h0F0);
        reset = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        step();
        check("abort_outputs", {27'd0, finished, collectFromCore0, collectFromCore1, underflow,
                                memoryCellReadWriteMode}, 32'd0);
        check("abort_message", {16'd0, message}, 32'd0);
        run_case("after_abort", 8'd1, 8'd2, 8'd2, 1'b0, 9'h000);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] sp;
            for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       sp = 8'hFF;
                1:       sp = 8'h00;
                default: sp = 8'($urandom);
            endcase
            img[0][15:8] = sp;
            run_case("rand", 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                     1'($urandom), 9'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
